// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes for the current state. It waits on memReady for
// instruction and data memory accesses, traps on an illegal opcode or on a
// memory wait timeout, and counts retired instructions.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   instruction        opcode field of fetched word, latched on fetch completion
//   memReady           memory access completes this cycle
//   zero               ALU zero flag, used by branches in EXEC
//   instrRead .. aluOp datapath control strobes (all 0 while rst is high)
//   trap, trapCause    sticky trap flag and cause (01 illegal, 10 timeout)
//   state              current FSM state (debug)
//   instrRetired       wrapping count of completed instructions
module multicycle_control_unit #(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] instruction,
  input  logic                memReady,
  input  logic                zero,
  output logic                instrRead,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                branch,
  output logic                memRead,
  output logic                memWrite,
  output logic                memToReg,
  output logic                aluSrc,
  output logic                regWrite,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                trap,
  output logic [1:0]          trapCause,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instrRetired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [OPCODE_W-1:0] OP_R = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_L = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_S = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_B = OPCODE_W'(7'b1100011);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [2:0]          state_r;
  logic [OPCODE_W-1:0] opcode_r;
  logic [WAIT_W-1:0]   wait_r;
  logic                trap_r;
  logic [1:0]          cause_r;
  logic [CNT_W-1:0]    retired_r;

  logic [2:0] next_state_s;
  logic [1:0] cause_next_s;
  logic       retire_s;
  logic       wait_full_s;

  assign wait_full_s = (wait_r == TIMEOUT_V);

  // State register plus opcode latch, wait counter, trap and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      opcode_r  <= '0;
      wait_r    <= '0;
      trap_r    <= 1'b0;
      cause_r   <= CAUSE_NONE;
      retired_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_FETCH && memReady) begin
        opcode_r <= instruction;
      end
      // Counter restarts on every transition and saturates while waiting.
      if (next_state_s != state_r) begin
        wait_r <= '0;
      end else if (!wait_full_s) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
      if (next_state_s == S_TRAP && state_r != S_TRAP) begin
        trap_r  <= 1'b1;
        cause_r <= cause_next_s;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Next-state logic; memReady on the saturated-counter cycle still completes.
  always_comb begin
    next_state_s = state_r;
    cause_next_s = CAUSE_NONE;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (memReady) begin
          next_state_s = S_DECODE;
        end else if (wait_full_s) begin
          next_state_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_r)
          OP_R, OP_I, OP_L, OP_S, OP_B: next_state_s = S_EXEC;
          default: begin
            next_state_s = S_TRAP;
            cause_next_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        case (opcode_r)
          OP_R, OP_I: next_state_s = S_WB;
          OP_L, OP_S: next_state_s = S_MEM;
          OP_B: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end
          default: begin
            next_state_s = S_TRAP;
            cause_next_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (memReady) begin
          if (opcode_r == OP_L) begin
            next_state_s = S_WB;
          end else begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end
        end else if (wait_full_s) begin
          next_state_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_TRAP:  next_state_s = S_TRAP;
      default: next_state_s = S_FETCH;
    endcase
  end

  // Strobe decode from registered state and latched opcode, forced off in reset.
  always_comb begin
    instrRead = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    branch    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    aluSrc    = 1'b0;
    regWrite  = 1'b0;
    aluOp     = ALUOP_W'(2'b00);
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          instrRead = 1'b1;
          irWrite   = memReady;
          pcWrite   = memReady;
        end
        S_EXEC: begin
          case (opcode_r)
            OP_R: aluOp = ALUOP_W'(2'b10);
            OP_I: begin
              aluOp  = ALUOP_W'(2'b10);
              aluSrc = 1'b1;
            end
            OP_L, OP_S: aluSrc = 1'b1;
            OP_B: begin
              aluOp   = ALUOP_W'(2'b01);
              branch  = 1'b1;
              pcWrite = zero;
            end
            default: aluOp = ALUOP_W'(2'b00);
          endcase
        end
        S_MEM: begin
          case (opcode_r)
            OP_L: memRead = 1'b1;
            OP_S: begin
              memWrite = 1'b1;
              aluSrc   = 1'b1;
            end
            default: memRead = 1'b0;
          endcase
        end
        S_WB: begin
          regWrite = 1'b1;
          memToReg = (opcode_r == OP_L);
        end
        default: regWrite = 1'b0;
      endcase
    end else begin
      regWrite = 1'b0;
    end
  end

  assign trap         = trap_r;
  assign trapCause    = cause_r;
  assign state        = state_r;
  assign instrRetired = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  typedef struct {
    logic        rst;
    logic [6:0]  instr;
    logic        mr;
    logic        z;
    logic [2:0]  st;
    logic [10:0] sb;
    logic        tr;
    logic [1:0]  tc;
    logic [3:0]  cnt;
  } vec_t;

  localparam logic [6:0] OPR = 7'h33;
  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] OPL = 7'h03;
  localparam logic [6:0] OPS = 7'h23;
  localparam logic [6:0] OPB = 7'h63;
  localparam logic [6:0] OPX = 7'h7F;

  // strobe word: {instrRead,irWrite,pcWrite,branch,memRead,memWrite,memToReg,aluSrc,regWrite,aluOp}
  localparam logic [10:0] SB_0   = 11'h000;
  localparam logic [10:0] SB_FR  = 11'h700;
  localparam logic [10:0] SB_FW  = 11'h400;
  localparam logic [10:0] SB_XR  = 11'h002;
  localparam logic [10:0] SB_XI  = 11'h00A;
  localparam logic [10:0] SB_XLS = 11'h008;
  localparam logic [10:0] SB_XB1 = 11'h181;
  localparam logic [10:0] SB_XB0 = 11'h081;
  localparam logic [10:0] SB_ML  = 11'h040;
  localparam logic [10:0] SB_MS  = 11'h028;
  localparam logic [10:0] SB_WR  = 11'h004;
  localparam logic [10:0] SB_WL  = 11'h014;

  logic clk, rst, memReady, zero;
  logic [6:0] instruction;

  logic instrRead, irWrite, pcWrite, branch, memRead, memWrite, memToReg, aluSrc, regWrite;
  logic [1:0] aluOp, trapCause;
  logic trap;
  logic [2:0] state;
  logic [3:0] instrRetired;

  logic w_instrRead, w_irWrite, w_pcWrite, w_branch, w_memRead, w_memWrite, w_memToReg;
  logic w_aluSrc, w_regWrite, w_trap;
  logic [1:0] w_aluOp, w_trapCause;
  logic [2:0] w_state;
  logic [31:0] w_instrRetired;

  int vectors = 0;
  int fails = 0;

  multicycle_control_unit #(.OPCODE_W(7), .ALUOP_W(2), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .memReady(memReady), .zero(zero),
    .instrRead(instrRead), .irWrite(irWrite), .pcWrite(pcWrite), .branch(branch),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .aluSrc(aluSrc),
    .regWrite(regWrite), .aluOp(aluOp), .trap(trap), .trapCause(trapCause),
    .state(state), .instrRetired(instrRetired)
  );

  multicycle_control_unit dutw (
    .clk(clk), .rst(rst), .instruction(instruction), .memReady(memReady), .zero(zero),
    .instrRead(w_instrRead), .irWrite(w_irWrite), .pcWrite(w_pcWrite), .branch(w_branch),
    .memRead(w_memRead), .memWrite(w_memWrite), .memToReg(w_memToReg), .aluSrc(w_aluSrc),
    .regWrite(w_regWrite), .aluOp(w_aluOp), .trap(w_trap), .trapCause(w_trapCause),
    .state(w_state), .instrRetired(w_instrRetired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [6:0] i, logic m, logic zz, logic [2:0] s,
                              logic [10:0] b, logic t, logic [1:0] c, logic [3:0] n);
    vec_t v;
    v.rst = r; v.instr = i; v.mr = m; v.z = zz;
    v.st = s; v.sb = b; v.tr = t; v.tc = c; v.cnt = n;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    logic [10:0] sb;
    @(negedge clk);
    rst = v.rst; instruction = v.instr; memReady = v.mr; zero = v.z;
    #1;
    sb = {instrRead, irWrite, pcWrite, branch, memRead, memWrite, memToReg, aluSrc, regWrite, aluOp};
    vectors++;
    if (state !== v.st) begin
      fails++; $display("FAIL %s state: got %0d expected %0d", tag, state, v.st);
    end
    if (sb !== v.sb) begin
      fails++; $display("FAIL %s strobes: got %03h expected %03h", tag, sb, v.sb);
    end
    if (trap !== v.tr || trapCause !== v.tc) begin
      fails++; $display("FAIL %s trap/cause: got %b/%b expected %b/%b", tag, trap, trapCause, v.tr, v.tc);
    end
    if (instrRetired !== v.cnt) begin
      fails++; $display("FAIL %s retired: got %0d expected %0d", tag, instrRetired, v.cnt);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; instruction = 7'h00; memReady = 1'b0; zero = 1'b0;
    @(posedge clk);

    tbl.push_back(mk(1'b1, 7'h00, 1'b0, 1'b0, 3'd0, SB_0,   1'b0, 2'b00, 4'd0));
    // R-type, memReady always high
    tbl.push_back(mk(1'b0, OPR,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd0));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd0));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd2, SB_XR,  1'b0, 2'b00, 4'd0));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd4, SB_WR,  1'b0, 2'b00, 4'd0));
    // L-type with three MEM wait cycles
    tbl.push_back(mk(1'b0, OPL,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd2, SB_XLS, 1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd3, SB_ML,  1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd3, SB_ML,  1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd3, SB_ML,  1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd3, SB_ML,  1'b0, 2'b00, 4'd1));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd4, SB_WL,  1'b0, 2'b00, 4'd1));
    // B-type zero=1 then zero=0
    tbl.push_back(mk(1'b0, OPB,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd2));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd2));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b1, 3'd2, SB_XB1, 1'b0, 2'b00, 4'd2));
    tbl.push_back(mk(1'b0, OPB,   1'b1, 1'b1, 3'd0, SB_FR,  1'b0, 2'b00, 4'd3));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b1, 3'd1, SB_0,   1'b0, 2'b00, 4'd3));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd2, SB_XB0, 1'b0, 2'b00, 4'd3));
    // I-type with one fetch wait cycle
    tbl.push_back(mk(1'b0, OPI,   1'b0, 1'b0, 3'd0, SB_FW,  1'b0, 2'b00, 4'd4));
    tbl.push_back(mk(1'b0, OPI,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd4));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd4));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd2, SB_XI,  1'b0, 2'b00, 4'd4));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd4, SB_WR,  1'b0, 2'b00, 4'd4));
    // S-type, immediate completion
    tbl.push_back(mk(1'b0, OPS,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd5));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd5));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd2, SB_XLS, 1'b0, 2'b00, 4'd5));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd3, SB_MS,  1'b0, 2'b00, 4'd5));
    // illegal opcode
    tbl.push_back(mk(1'b0, OPX,   1'b1, 1'b0, 3'd0, SB_FR,  1'b0, 2'b00, 4'd6));
    tbl.push_back(mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0,   1'b0, 2'b00, 4'd6));

    foreach (tbl[k]) apply($sformatf("tbl%0d", k), tbl[k]);

    // TRAP holds for 20 cycles regardless of memReady
    for (int k = 0; k < 20; k++)
      apply($sformatf("trap_hold%0d", k), mk(1'b0, OPR, k[0], 1'b0, 3'd5, SB_0, 1'b1, 2'b01, 4'd6));
    apply("trap_rst", mk(1'b1, 7'h00, 1'b1, 1'b0, 3'd5, SB_0, 1'b1, 2'b01, 4'd6));

    // S-type timing out in MEM
    apply("s_to_fetch", mk(1'b0, OPS, 1'b1, 1'b0, 3'd0, SB_FR, 1'b0, 2'b00, 4'd0));
    apply("s_to_dec",   mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd1, SB_0, 1'b0, 2'b00, 4'd0));
    apply("s_to_exec",  mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd2, SB_XLS, 1'b0, 2'b00, 4'd0));
    for (int k = 0; k < 16; k++)
      apply($sformatf("s_to_mem%0d", k), mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd3, SB_MS, 1'b0, 2'b00, 4'd0));
    apply("s_to_trap", mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd5, SB_0, 1'b1, 2'b10, 4'd0));
    apply("s_to_rst",  mk(1'b1, 7'h00, 1'b0, 1'b0, 3'd5, SB_0, 1'b1, 2'b10, 4'd0));

    // S-type with memReady on the saturated-counter cycle completes
    apply("s_ok_fetch", mk(1'b0, OPS, 1'b1, 1'b0, 3'd0, SB_FR, 1'b0, 2'b00, 4'd0));
    apply("s_ok_dec",   mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd1, SB_0, 1'b0, 2'b00, 4'd0));
    apply("s_ok_exec",  mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd2, SB_XLS, 1'b0, 2'b00, 4'd0));
    for (int k = 0; k < 16; k++)
      apply($sformatf("s_ok_mem%0d", k), mk(1'b0, 7'h00, (k == 15), 1'b0, 3'd3, SB_MS, 1'b0, 2'b00, 4'd0));

    // Fetch timeout
    for (int k = 0; k < 16; k++)
      apply($sformatf("f_to%0d", k), mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd0, SB_FW, 1'b0, 2'b00, 4'd1));
    apply("f_to_trap", mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd5, SB_0, 1'b1, 2'b10, 4'd1));
    apply("f_to_rst",  mk(1'b1, 7'h00, 1'b0, 1'b0, 3'd5, SB_0, 1'b1, 2'b10, 4'd1));

    // 16 back-to-back I-type: 4-bit counter wraps to 0
    for (int k = 0; k < 16; k++) begin
      logic [3:0] n;
      n = 4'(k);
      apply($sformatf("wrap_f%0d", k), mk(1'b0, OPI, 1'b1, 1'b0, 3'd0, SB_FR, 1'b0, 2'b00, n));
      apply($sformatf("wrap_d%0d", k), mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd1, SB_0, 1'b0, 2'b00, n));
      apply($sformatf("wrap_e%0d", k), mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd2, SB_XI, 1'b0, 2'b00, n));
      apply($sformatf("wrap_w%0d", k), mk(1'b0, 7'h00, 1'b1, 1'b0, 3'd4, SB_WR, 1'b0, 2'b00, n));
    end

    // L-type reset mid-MEM
    apply("lr_fetch", mk(1'b0, OPL, 1'b1, 1'b0, 3'd0, SB_FR, 1'b0, 2'b00, 4'd0));
    vectors++;
    if (w_instrRetired !== 32'd16) begin
      fails++; $display("FAIL wide_retired: got %0d expected 16", w_instrRetired);
    end
    apply("lr_dec",  mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd1, SB_0, 1'b0, 2'b00, 4'd0));
    apply("lr_exec", mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd2, SB_XLS, 1'b0, 2'b00, 4'd0));
    apply("lr_mem",  mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd3, SB_ML, 1'b0, 2'b00, 4'd0));
    apply("lr_rst0", mk(1'b1, 7'h00, 1'b0, 1'b0, 3'd3, SB_0, 1'b0, 2'b00, 4'd0));
    apply("lr_rst1", mk(1'b1, 7'h00, 1'b0, 1'b0, 3'd0, SB_0, 1'b0, 2'b00, 4'd0));
    apply("lr_after", mk(1'b0, 7'h00, 1'b0, 1'b0, 3'd0, SB_FW, 1'b0, 2'b00, 4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RISC-V control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and issues per-state control strobes.
- Handshakes with instruction/data memory via a ready signal, with a configurable wait-state timeout.
- Latches the opcode, traps on illegal opcodes or memory timeout, and counts retired instructions. Sits between the instruction register and the datapath muxes/ALU control.

Parameters:
OPCODE_W, 7, opcode width; decoding uses the RV32I major opcodes below
ALUOP_W, 2, aluOp width
MEM_TIMEOUT, 15, max wait cycles for memReady before trapping; must be >= 1
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
instruction  input  OPCODE_W  opcode field of the memory read data; sampled on fetch completion
memReady  input  1  memory completes the current instrRead/memRead/memWrite this cycle
zero  input  1  ALU zero flag, valid in EXEC
instrRead  output  1  instruction fetch request
irWrite  output  1  opcode/IR load strobe
pcWrite  output  1  PC update strobe (PC+4 or branch target)
branch  output  1  PC source select = branch target
memRead  output  1  data memory read request
memWrite  output  1  data memory write request
memToReg  output  1  writeback source = memory
aluSrc  output  1  ALU operand B = immediate
regWrite  output  1  register file write enable
aluOp  output  ALUOP_W  00 add, 01 branch compare, 10 funct decode
trap  output  1  sticky trap indicator
trapCause  output  2  01 illegal opcode, 10 memory timeout, 00 none
state  output  3  current state encoding, for debug
instrRetired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011. Any other opcode is illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next cycle.
- Reset (rst high at a clock edge, any state, including mid-wait):
  - state=FETCH, opcode register=0, wait counter=0, trap=0, trapCause=00, instrRetired=0.
  - All strobe outputs are 0 while rst is high.
- Outputs are decoded from the registered state and the latched opcode. Any output not listed for a state is 0.
- FETCH:
  - instrRead=1.
  - When memReady=1: irWrite=1, pcWrite=1, branch=0, opcode latched from instruction, next state DECODE.
  - Otherwise the wait counter increments. If the counter reaches MEM_TIMEOUT with memReady still 0, go to TRAP with cause 10.
- DECODE: one cycle, no strobes. Legal opcode -> EXEC; illegal -> TRAP with cause 01.
- EXEC:
  - R: aluOp=10, aluSrc=0, next WB.
  - I: aluOp=10, aluSrc=1, next WB.
  - L/S: aluOp=00, aluSrc=1, next MEM.
  - B: aluOp=01, aluSrc=0, branch=1, pcWrite=zero, next FETCH; retires.
- MEM:
  - L: memRead=1; on memReady go to WB.
  - S: memWrite=1, aluSrc=1; on memReady go to FETCH and retire.
  - Same timeout rule as FETCH, cause 10.
  - Strobes hold steady until memReady.
- WB: regWrite=1; memToReg=1 for L, 0 for R/I. Next FETCH; retires.
- Wait counter clears on every state transition and saturates at MEM_TIMEOUT. memReady arriving in the same cycle the counter hits MEM_TIMEOUT counts as completion, not timeout.
- TRAP: trap=1, trapCause held, all strobes 0. Stays in TRAP until rst.
- instrRetired increments by 1 on each retiring transition and wraps from all-ones to 0.
- Latency with memReady=1 on the first request cycle: R/I 4 cycles, L 5, S 4, B 3.
- memReady outside FETCH/MEM-wait is ignored.

Test Plan:
- rst for 2 cycles, then R-type (0110011) with memReady=1 always -> state sequence 0,1,2,4,0. In EXEC aluOp=10 and aluSrc=0. WB has regWrite=1, memToReg=0. instrRetired=1.
- L-type, memReady low for 3 cycles in MEM -> memRead=1 held for 4 cycles, then WB with regWrite=1, memToReg=1. Total 8 cycles. In EXEC the control word {aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp}=10000000.
- B-type with zero=1 then zero=0 -> EXEC gives branch=1, aluOp=01, pcWrite=1 then 0. Each takes 3 cycles back to FETCH; instrRetired increments twice.
- Opcode 1111111 -> DECODE then TRAP; trap=1, trapCause=01. TRAP persists for 20 cycles despite memReady toggling. rst returns state=0 and clears trap.
- S-type with memReady held low in MEM, MEM_TIMEOUT=15 -> TRAP with trapCause=10 after 15 wait cycles. Repeat with memReady rising exactly on cycle 15 -> completes to FETCH with no trap.
- CNT_W=4: 16 back-to-back I-type instructions -> instrRetired wraps 15->0. rst asserted mid-MEM of an L -> next cycle state=0, all strobes 0.
